// File: rtl/transmitter.sv
// transmitter: serial frame transmitter (start bit, MSB-first data, stop bits), idle-high line.
// Optional build macro TX_PARITY_EN inserts one even-parity bit between the data and stop bits.
module transmitter #(
  parameter int nbits      = 8,
  parameter int stpbits    = 2,
  parameter int final_time = 9,
  parameter int nticks     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_start,
  input  logic [nbits-1:0] tx_din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int TMR_W   = (final_time > 0) ? $clog2(final_time + 1) : 1;
  localparam int TCK_W   = (nticks > 1) ? $clog2(nticks) : 1;
  localparam int BIT_MAX = (nbits > stpbits) ? nbits : stpbits;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(final_time);
  localparam logic [TCK_W-1:0] TCK_LAST  = TCK_W'(nticks - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(nbits - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(stpbits - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [TCK_W-1:0] tick_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [nbits-1:0] shreg;
  logic             s_tick;
  logic             bit_end;

`ifdef TX_PARITY_EN
  logic par_bit;

  function automatic logic even_parity(input logic [nbits-1:0] d);
    return ^d;
  endfunction
`endif

  // A bit period ends on the nticks-th sample tick; timer and tick count rest at 0 in IDLE.
  assign s_tick  = (state != IDLE) && (timer == TMR_LAST);
  assign bit_end = s_tick && (tick_cnt == TCK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer    <= '0;
      tick_cnt <= '0;
    end else if (state == IDLE) begin
      timer    <= '0;
      tick_cnt <= '0;
    end else begin
      timer <= s_tick ? '0 : timer + 1'b1;
      if (s_tick)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
    end
  end

  // tx is updated on the same edge as the state, so each bit shows for exactly one bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            shreg   <= tx_din;
`ifdef TX_PARITY_EN
            par_bit <= even_parity(tx_din);
`endif
            bit_cnt <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[nbits-1];
            shreg   <= shreg << 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
`ifdef TX_PARITY_EN
              tx      <= par_bit;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              bit_cnt <= '0;
              state   <= STOP;
`endif
            end else begin
              tx      <= shreg[nbits-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: table-driven frames plus hand sequences, checked by a serial-line scoreboard.
module tb_transmitter;

  localparam int NB = 8;
  localparam int SB = 2;
  localparam int FT = 9;
  localparam int NT = 16;
  localparam int BIT_CLK = NT * (FT + 1);
`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_CLK = (1 + NB + PB + SB) * BIT_CLK;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tx_start = 1'b0;
  logic [NB-1:0] tx_din = '0;
  logic          tx, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] exp_q[$];

  transmitter #(.nbits(NB), .stpbits(SB), .final_time(FT), .nticks(NT)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_din(tx_din),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_bit(input logic [NB-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= NB) return d[NB-b];
`ifdef TX_PARITY_EN
    if (b == NB + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Serial-line monitor: decodes each frame, compares against the queued payload.
  int            mon_pos = -1;
  int            mon_bad = 0;
  int            done_cnt = 0;
  int            stray_done = 0;
  int            mon_bi;
  logic [NB-1:0] mon_exp = '0;
  logic [NB-1:0] mon_got = '0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_pos = -1;
    end else if (mon_pos < 0) begin
      if (tx_done === 1'b1) stray_done++;
      if (tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: tx=0 with no frame queued (t=%0t)", $time);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = '0;
          mon_bad = 0;
          mon_pos = 0;
        end
      end
    end else begin
      mon_pos++;
    end
    if (reset && mon_pos >= 0) begin
      if (mon_pos < FRAME_CLK) begin
        mon_bi = mon_pos / BIT_CLK;
        if (tx !== model_bit(mon_exp, mon_bi) || tx_busy !== 1'b1 || tx_done !== 1'b0)
          mon_bad++;
        if ((mon_pos % BIT_CLK) == BIT_CLK / 2 && mon_bi >= 1 && mon_bi <= NB)
          mon_got = {mon_got[NB-2:0], tx};
      end else begin
        chk("frame_data", 32'(mon_got), 32'(mon_exp));
        chk("frame_bad_cycles", mon_bad, 0);
        chk("frame_done_pulse", 32'(tx_done), 1);
        chk("frame_busy_drop", 32'(tx_busy), 0);
        done_cnt++;
        mon_pos = -1;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b0 && n < 4 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * FRAME_CLK) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: tx_busy=%b after %0d cycles, want 0", tx_busy, n);
    end
  endtask

  // Called at a negedge; returns #1 after the accepting edge with tx_din scrambled.
  task automatic send(input logic [NB-1:0] d, input int gap);
    repeat (gap) @(negedge clk);
    tx_din   = d;
    tx_start = 1'b1;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    tx_din   = ~d;
  endtask

  task automatic hand_frame(input logic [NB-1:0] d, input logic [15:0] pat, input int nb,
                            input string tag);
    int lat;
    int k;
    logic [15:0] p;
    p = pat;
    wait_idle();
    send(d, 0);
    lat = 0;
    while (lat < 3 * FRAME_CLK) begin
      @(posedge clk);
      lat++;
      #1;
      if ((lat % BIT_CLK) == BIT_CLK / 2) begin
        k = lat / BIT_CLK;
        if (k < nb) chk({tag, "_bit"}, 32'(tx), 32'(p[nb-1-k]));
      end
      if (tx_done === 1'b1) break;
    end
    chk({tag, "_latency"}, lat, FRAME_CLK);
  endtask

  typedef struct {
    logic [NB-1:0] din;
    int            gap;
  } vec_t;

  vec_t vecs[6];
  int   d0;
  int   n;

  initial begin
    vecs[0] = '{din: 8'h5A, gap: 3};
    vecs[1] = '{din: 8'h81, gap: 0};
    vecs[2] = '{din: 8'hFF, gap: 0};
    vecs[3] = '{din: 8'h00, gap: 5};
    vecs[4] = '{din: 8'h01, gap: 1};
    vecs[5] = '{din: 8'h80, gap: 0};

    #2 reset = 1'b0;
    #1;
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(tx_busy), 0);
    chk("reset_done", 32'(tx_done), 0);
    tx_start = 1'b1;
    tx_din   = 8'h3C;
    repeat (3) @(negedge clk);
    chk("reset_holds_busy", 32'(tx_busy), 0);
    chk("reset_holds_tx", 32'(tx), 1);
    tx_start = 1'b0;
    reset    = 1'b1;

`ifdef TX_PARITY_EN
    hand_frame(8'hA5, 16'b010100101011, 12, "a5");
`else
    hand_frame(8'hA5, 16'b01010010111, 11, "a5");
`endif

    for (int i = 0; i < 6; i++) begin
      wait_idle();
      send(vecs[i].din, vecs[i].gap);
    end

`ifdef TX_PARITY_EN
    hand_frame(8'h07, 16'b000000111111, 12, "x07");
`else
    hand_frame(8'h07, 16'b00000011111, 11, "x07");
`endif

    // tx_start held high across two frames: second accepted right after tx_done.
    wait_idle();
    #1;
    d0 = done_cnt;
    tx_din   = 8'h3C;
    tx_start = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    tx_din = 8'hC3;
    exp_q.push_back(8'hC3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_done !== 1'b1 && n < 3 * FRAME_CLK);
    chk("b2b_first_done", 32'(tx_done), 1);
    @(negedge clk);
    chk("b2b_busy", 32'(tx_busy), 1);
    chk("b2b_tx_start_bit", 32'(tx), 0);
    tx_start = 1'b0;
    wait_idle();
    #1;
    chk("b2b_done_count", done_cnt - d0, 2);

    // Request while busy is ignored.
    wait_idle();
    send(8'h00, 2);
    repeat (498) @(negedge clk);
    tx_din   = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (300) @(negedge clk);
    chk("ignored_busy", 32'(tx_busy), 0);
    chk("ignored_tx", 32'(tx), 1);

    // Reset mid-frame, then a fresh frame accepted on the first edge after release.
    wait_idle();
    send(8'h66, 1);
    repeat (699) @(posedge clk);
    #2;
    chk("abort_pre_tx", 32'(tx), 0);
    reset = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 1);
    chk("abort_busy", 32'(tx_busy), 0);
    chk("abort_done", 32'(tx_done), 0);
    #1;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(tx_done), 0);
    tx_din   = 8'h81;
    tx_start = 1'b1;
    exp_q.push_back(8'h81);
    reset    = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    tx_din   = 8'h00;
    chk("rearm_busy", 32'(tx_busy), 1);
    chk("rearm_tx", 32'(tx), 0);
    wait_idle();
    #1;
    chk("rearm_done_count", done_cnt - d0, 1);

    n = 0;
    while ((exp_q.size() != 0 || mon_pos >= 0) && n < 2 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("stray_done", stray_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter nbits, default 8: data bits per frame.
REQ-002 Parameter stpbits, default 2: stop bits per frame.
REQ-003 Parameter final_time, default 9: the sample tick fires every final_time+1 clk cycles.
REQ-004 Parameter nticks, default 16: sample ticks per bit period.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port tx_start, input, 1: request to send; sampled only in IDLE.
REQ-008 Port tx_din, input, nbits: frame payload; captured when the request is accepted.
REQ-009 Port tx, output, 1: serial line, idle high.
REQ-010 Port tx_busy, output, 1: high from the cycle after acceptance until the frame ends.
REQ-011 Port tx_done, output, 1: single-cycle pulse when the last stop bit completes.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY (only with the macro) and STOP, in one registered state machine.
REQ-013 The tick timer SHALL count 0..final_time, assert s_tick for one cycle at final_time, then wrap to 0.
REQ-014 A bit counter SHALL count s_tick pulses; the bit ends on the nticks-th tick, giving a bit period of nticks*(final_time+1) = 160 clk at defaults.
REQ-015 IDLE with tx_start=1 SHALL capture tx_din into a shift register, clear the timer and tick counter, and enter START on the next edge.
REQ-016 START SHALL drive tx=0 for one bit period, then enter DATA.
REQ-017 DATA SHALL send nbits bits MSB first, one per bit period, to match the receiver's left-shift assembly, then enter PARITY or STOP.
REQ-018 STOP SHALL drive tx=1 for stpbits bit periods, then pulse tx_done, drop tx_busy and return to IDLE.
REQ-019 tx SHALL be registered, and every bit SHALL appear on tx on the cycle after its state is entered.
REQ-020 tx_start while busy SHALL be ignored, and tx_din changes after acceptance SHALL NOT affect the frame.
REQ-021 tx_start high in the cycle after tx_done SHALL be accepted, giving back-to-back frames with no idle bit.
REQ-022 Frame length SHALL be (1+nbits+stpbits) bit periods, which is 1760 clk at defaults.

Reset
REQ-023 Reset low SHALL immediately force: tx=1, tx_busy=0, tx_done=0, state IDLE, timer 0, counters 0, shift register 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no tx_done pulse.
REQ-025 After reset deasserts, the block SHALL accept tx_start on the first clock edge.

Configuration
REQ-026 Macro TX_PARITY_EN defined: PARITY sends one even-parity bit (XOR of the captured data) for one bit period between DATA and STOP.
REQ-027 Macro TX_PARITY_EN defined: frame length is (2+nbits+stpbits) bit periods.
REQ-028 Macro TX_PARITY_EN undefined: the PARITY state and its logic are absent, and DATA goes straight to STOP.

Verification
REQ-029 Send 0xA5 at defaults -> tx reads 0,1,0,1,0,0,1,0,1,1,1, each bit 160 clk, then a tx_done pulse 1760 clk after acceptance.
REQ-030 Hold tx_start high continuously -> frames 0x3C then 0xC3 sent back-to-back, with tx_done pulsing once per frame.
REQ-031 Pulse tx_start with 0xFF at clk 500 of a 0x00 frame -> ignored; tx carries 0x00 only.
REQ-032 Drop reset at clk 700 of a frame -> tx=1 and tx_busy=0 at once, no tx_done; a new 0x81 frame then sends correctly.
REQ-033 With TX_PARITY_EN, send 0x07 -> parity bit 1 after the data, frame 1920 clk.
REQ-034 Loopback into the receiver with 0x5A -> rx_dout=0x5A with rx_done.
